// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter slice: FSM states, owners,
// RISC-V load/store funct3 encodings and the access-size decode.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESPOND   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_class_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Encodings outside the load/store set fall back to a full word.
  function automatic size_class_e size_class(input logic [2:0] f3);
    size_class_e sc;
    case (f3)
      F3_LB, F3_LBU: sc = SZ_BYTE;
      F3_LH, F3_LHU: sc = SZ_HALF;
      default:       sc = SZ_WORD;
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;

  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_req_addr;
  logic        dc_req_we;
  logic [2:0]  dc_req_size;
  logic [31:0] dc_req_wdata;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        dc_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_addr, dc_req_we, dc_req_size, dc_req_wdata,
    output dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_addr, dc_req_we, dc_req_size, dc_req_wdata,
    input  dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane formatting: store mask/replication/misalignment and
// load lane extraction with sign or zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata_sh,
  output logic        st_misaligned,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane_s;

  // Store side: replicate the datum across lanes so the mask alone selects it.
  always_comb begin
    st_wmask      = 4'b0000;
    st_wdata_sh   = 32'd0;
    st_misaligned = 1'b0;
    case (size_class(st_size))
      SZ_BYTE: begin
        st_wmask    = 4'b0001 << st_off;
        st_wdata_sh = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_wmask      = 4'b0011 << st_off;
        st_wdata_sh   = {2{st_wdata[15:0]}};
        st_misaligned = st_off[0];
      end
      default: begin
        st_wmask      = 4'b1111;
        st_wdata_sh   = st_wdata;
        st_misaligned = (st_off != 2'b00);
      end
    endcase
  end

  // Load side: bring lane off down to bit 0, then extend; funct3[2] selects unsigned.
  always_comb begin
    lane_s  = ld_rdata >> {ld_off, 3'b000};
    ld_data = 32'd0;
    case (size_class(ld_size))
      SZ_BYTE: begin
        if (ld_size[2]) begin
          ld_data = {24'd0, lane_s[7:0]};
        end else begin
          ld_data = {{24{lane_s[7]}}, lane_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (ld_size[2]) begin
          ld_data = {16'd0, lane_s[15:0]};
        end else begin
          ld_data = {{16{lane_s[15]}}, lane_s[15:0]};
        end
      end
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, with a starvation bound on the fetch side.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int              CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C = CW'(STARVE_LIMIT);

  arb_state_e    state_r, state_nxt_s;
  logic [CW-1:0] starve_r;
  owner_e        owner_r;
  logic [2:0]    size_r;
  logic [1:0]    off_r;
  logic [31:0]   mem_addr_r;
  logic          mem_we_r;
  logic [3:0]    mem_wmask_r;
  logic [31:0]   mem_wdata_r;
  logic          ic_resp_valid_r;
  logic [31:0]   ic_resp_data_r;
  logic          dc_resp_valid_r;
  logic [31:0]   dc_resp_data_r;
  logic          dc_resp_err_r;

  logic          ic_win_s, dc_win_s;
  logic          ic_ready_s, dc_ready_s, mem_valid_s;
  logic [3:0]    st_wmask_s;
  logic [31:0]   st_wdata_s;
  logic          st_mis_s;
  logic [31:0]   ld_data_s;

  mem_align u_align (
    .st_size       (bus.dc_req_size),
    .st_off        (bus.dc_req_addr[1:0]),
    .st_wdata      (bus.dc_req_wdata),
    .st_wmask      (st_wmask_s),
    .st_wdata_sh   (st_wdata_s),
    .st_misaligned (st_mis_s),
    .ld_size       (size_r),
    .ld_off        (off_r),
    .ld_rdata      (bus.mem_resp_data),
    .ld_data       (ld_data_s)
  );

  // Grant: data port by default, fetch once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    ic_win_s = 1'b0;
    dc_win_s = 1'b0;
    if (bus.ic_req_valid && (!bus.dc_req_valid || (starve_r == LIMIT_C))) begin
      ic_win_s = 1'b1;
    end else if (bus.dc_req_valid) begin
      dc_win_s = 1'b1;
    end else begin
      ic_win_s = 1'b0;
      dc_win_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; misaligned data requests skip memory entirely.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ic_win_s) begin
          state_nxt_s = ST_ISSUE;
        end else if (dc_win_s) begin
          state_nxt_s = st_mis_s ? ST_RESPOND : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_req_ready) begin
          state_nxt_s = mem_we_r ? ST_RESPOND : ST_WAIT_RESP;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_RESP: begin
        if (bus.mem_resp_valid) begin
          state_nxt_s = ST_RESPOND;
        end else begin
          state_nxt_s = ST_WAIT_RESP;
        end
      end
      ST_RESPOND: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state and the request valids.
  always_comb begin
    ic_ready_s  = 1'b0;
    dc_ready_s  = 1'b0;
    mem_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ic_ready_s = ic_win_s;
        dc_ready_s = dc_win_s;
      end
      ST_ISSUE: mem_valid_s = 1'b1;
      default: begin
        ic_ready_s  = 1'b0;
        dc_ready_s  = 1'b0;
        mem_valid_s = 1'b0;
      end
    endcase
  end

  // Starve counter only moves in IDLE, where grants happen.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_r <= '0;
    end else if (state_r == ST_IDLE) begin
      if (!bus.ic_req_valid || ic_win_s) begin
        starve_r <= '0;
      end else if (starve_r != LIMIT_C) begin
        starve_r <= starve_r + CW'(1);
      end
    end
  end

  // Capture the winning request with memory fields already formatted.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= OWN_IC;
      size_r      <= 3'b000;
      off_r       <= 2'b00;
      mem_addr_r  <= 32'd0;
      mem_we_r    <= 1'b0;
      mem_wmask_r <= 4'b0000;
      mem_wdata_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && ic_win_s) begin
      owner_r     <= OWN_IC;
      size_r      <= F3_LW;
      off_r       <= 2'b00;
      mem_addr_r  <= {bus.ic_req_addr[31:2], 2'b00};
      mem_we_r    <= 1'b0;
      mem_wmask_r <= 4'b0000;
      mem_wdata_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && dc_win_s) begin
      owner_r     <= OWN_DC;
      size_r      <= bus.dc_req_size;
      off_r       <= bus.dc_req_addr[1:0];
      mem_addr_r  <= {bus.dc_req_addr[31:2], 2'b00};
      mem_we_r    <= bus.dc_req_we;
      mem_wmask_r <= bus.dc_req_we ? st_wmask_s : 4'b0000;
      mem_wdata_r <= bus.dc_req_we ? st_wdata_s : 32'd0;
    end
  end

  // Response registers are loaded on the way into RESPOND so they pulse for exactly that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_resp_valid_r <= 1'b0;
      ic_resp_data_r  <= 32'd0;
      dc_resp_valid_r <= 1'b0;
      dc_resp_data_r  <= 32'd0;
      dc_resp_err_r   <= 1'b0;
    end else begin
      ic_resp_valid_r <= 1'b0;
      ic_resp_data_r  <= 32'd0;
      dc_resp_valid_r <= 1'b0;
      dc_resp_data_r  <= 32'd0;
      dc_resp_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dc_win_s && st_mis_s) begin
            dc_resp_valid_r <= 1'b1;
            dc_resp_err_r   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.mem_req_ready && mem_we_r) begin
            dc_resp_valid_r <= 1'b1;
          end
        end
        ST_WAIT_RESP: begin
          if (bus.mem_resp_valid && (owner_r == OWN_IC)) begin
            ic_resp_valid_r <= 1'b1;
            ic_resp_data_r  <= bus.mem_resp_data;
          end else if (bus.mem_resp_valid) begin
            dc_resp_valid_r <= 1'b1;
            dc_resp_data_r  <= ld_data_s;
          end
        end
        default: begin
          ic_resp_valid_r <= 1'b0;
          dc_resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ic_req_ready  = ic_ready_s;
  assign bus.dc_req_ready  = dc_ready_s;
  assign bus.mem_req_valid = mem_valid_s;
  assign bus.mem_req_addr  = mem_addr_r;
  assign bus.mem_req_we    = mem_we_r;
  assign bus.mem_req_wmask = mem_wmask_r;
  assign bus.mem_req_wdata = mem_wdata_r;
  assign bus.ic_resp_valid = ic_resp_valid_r;
  assign bus.ic_resp_data  = ic_resp_data_r;
  assign bus.dc_resp_valid = dc_resp_valid_r;
  assign bus.dc_resp_data  = dc_resp_data_r;
  assign bus.dc_resp_err   = dc_resp_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention,
// back-pressure/reset sequences and random traffic against a behavioural model.
module tb_mem_arbiter;

  typedef struct {
    bit          is_ic;
    logic [31:0] addr;
    bit          we;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          rdy_wait;
    int          rsp_wait;
    bit          exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          was_ic;
    bit          err;
    logic [31:0] data;
    int          lat;
    bit          saw_req;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    bit          unstable;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    else if (f3 == 3'd1 || f3 == 3'd5) return 2;
    else return 4;
  endfunction

  // Reference: derived from lane arithmetic, not from the RTL structure.
  function automatic vec_t model(input bit is_ic, input logic [31:0] addr, input bit we,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input logic [31:0] mdata, input int rdy, input int rsp);
    vec_t   v;
    int     n;
    int     off;
    longint lane;
    v = '{default: 0};
    v.is_ic = is_ic; v.addr = addr; v.we = is_ic ? 1'b0 : we; v.size = size;
    v.wdata = wdata; v.mdata = mdata; v.rdy_wait = rdy; v.rsp_wait = rsp;
    off = int'(addr % 4);
    if (is_ic) begin
      v.exp_data = mdata;
      v.exp_lat  = 3 + rdy + rsp;
    end else begin
      n = nbytes(size);
      if (off % n != 0) begin
        v.exp_err = 1'b1;
        v.exp_lat = 1;
      end else if (we) begin
        v.exp_lat  = 2 + rdy;
        v.exp_mask = 4'(((1 << n) - 1) << off);
        if (n == 1) v.exp_wdata = (wdata % 256) * 32'h0101_0101;
        else if (n == 2) v.exp_wdata = (wdata % 65536) * 32'h0001_0001;
        else v.exp_wdata = wdata;
      end else begin
        v.exp_lat = 3 + rdy + rsp;
        lane = longint'(mdata >> (8 * off));
        if (n == 1) begin
          lane = lane % 256;
          if (size == 3'd0 && lane >= 128) lane = lane - 256;
        end else if (n == 2) begin
          lane = lane % 65536;
          if (size == 3'd1 && lane >= 32768) lane = lane - 65536;
        end
        v.exp_data = 32'(lane);
      end
    end
    return v;
  endfunction

  // Drive one request and play the memory side until the response pulse.
  task automatic txn(input vec_t v, output res_t r);
    int w;
    int hold;
    int rsp_at;
    r = '{default: 0};
    r.lat = -1;
    @(negedge clk);
    chk("quiet_before_req", {31'd0, bus.ic_resp_valid | bus.dc_resp_valid}, 32'd0);
    if (v.is_ic) begin
      bus.ic_req_valid = 1'b1; bus.ic_req_addr = v.addr;
    end else begin
      bus.dc_req_valid = 1'b1; bus.dc_req_addr = v.addr; bus.dc_req_we = v.we;
      bus.dc_req_size = v.size; bus.dc_req_wdata = v.wdata;
    end
    #1;
    w = 0;
    while (((v.is_ic ? bus.ic_req_ready : bus.dc_req_ready) !== 1'b1) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(negedge clk);
    bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
    bus.ic_req_addr = $urandom(); bus.dc_req_addr = $urandom(); bus.dc_req_wdata = $urandom();
    bus.dc_req_size = 3'($urandom_range(0, 7)); bus.dc_req_we = 1'($urandom_range(0, 1));
    hold = 0;
    rsp_at = -1;
    for (int c = 1; c <= 60; c++) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom();
      if (c == rsp_at) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = v.mdata;
      end
      if (bus.ic_resp_valid || bus.dc_resp_valid) begin
        r.was_ic = bus.ic_resp_valid;
        r.err    = bus.dc_resp_err;
        r.data   = bus.ic_resp_valid ? bus.ic_resp_data : bus.dc_resp_data;
        r.lat    = c;
        break;
      end
      if (bus.mem_req_valid) begin
        if (!r.saw_req) begin
          r.saw_req = 1'b1; r.addr = bus.mem_req_addr; r.we = bus.mem_req_we;
          r.mask = bus.mem_req_wmask; r.wdata = bus.mem_req_wdata;
        end else if (r.addr !== bus.mem_req_addr || r.we !== bus.mem_req_we ||
                     r.mask !== bus.mem_req_wmask || r.wdata !== bus.mem_req_wdata) begin
          r.unstable = 1'b1;
        end
        if (hold >= v.rdy_wait) begin
          bus.mem_req_ready = 1'b1;
          if (!(v.we && !v.is_ic)) rsp_at = c + 1 + v.rsp_wait;
        end else begin
          hold++;
          bus.mem_resp_valid = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_txn(input string tag, input vec_t v, input res_t r);
    chk({tag, "_lat"}, 32'(r.lat), 32'(v.exp_lat));
    chk({tag, "_owner"}, 32'(r.was_ic), 32'(v.is_ic));
    chk({tag, "_err"}, 32'(r.err), 32'(v.exp_err));
    chk({tag, "_data"}, r.data, v.exp_data);
    chk({tag, "_memreq"}, 32'(r.saw_req), 32'(!v.exp_err));
    if (r.saw_req && !v.exp_err) begin
      chk({tag, "_addr"}, r.addr, v.addr & 32'hFFFF_FFFC);
      chk({tag, "_we"}, 32'(r.we), 32'(v.we));
      chk({tag, "_mask"}, 32'(r.mask), 32'(v.exp_mask));
      chk({tag, "_stable"}, 32'(r.unstable), 32'd0);
      if (v.we) chk({tag, "_wdata"}, r.wdata, v.exp_wdata);
    end
  endtask

  function automatic vec_t mk(input bit is_ic, input logic [31:0] addr, input bit we,
                              input logic [2:0] size, input logic [31:0] wdata,
                              input logic [31:0] mdata, input int rdy, input int rsp,
                              input bit err, input logic [31:0] data, input logic [3:0] mask,
                              input logic [31:0] wd, input int lat);
    vec_t v;
    v.is_ic = is_ic; v.addr = addr; v.we = we; v.size = size; v.wdata = wdata;
    v.mdata = mdata; v.rdy_wait = rdy; v.rsp_wait = rsp; v.exp_err = err;
    v.exp_data = data; v.exp_mask = mask; v.exp_wdata = wd; v.exp_lat = lat;
    return v;
  endfunction

  function automatic bit outs_nonzero();
    return |{bus.ic_req_ready, bus.ic_resp_valid, bus.ic_resp_data, bus.dc_req_ready,
             bus.dc_resp_valid, bus.dc_resp_data, bus.dc_resp_err, bus.mem_req_valid,
             bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wmask, bus.mem_req_wdata};
  endfunction

  initial begin
    vec_t vt[17];
    vec_t v;
    res_t r;
    bit   grants_ic[10];
    int   g;

    bus.ic_req_valid = 1'b0; bus.ic_req_addr = 32'd0;
    bus.dc_req_valid = 1'b0; bus.dc_req_addr = 32'd0; bus.dc_req_we = 1'b0;
    bus.dc_req_size = 3'd0; bus.dc_req_wdata = 32'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {31'd0, outs_nonzero()}, 32'd0);
    reset = 1'b0;

    //           ic addr           we size  wdata          mdata          rdy rsp err data           mask     wdata          lat
    vt[0]  = mk(0, 32'h0000_0100, 1, 3'd2, 32'hDEAD_BEEF, 32'h0,         0, 0, 0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 2);
    vt[1]  = mk(0, 32'h0000_0103, 1, 3'd0, 32'h0000_00A5, 32'h0,         0, 0, 0, 32'h0,         4'b1000, 32'hA5A5_A5A5, 2);
    vt[2]  = mk(0, 32'h0000_0103, 0, 3'd0, 32'h0,         32'hA500_0000, 0, 0, 0, 32'hFFFF_FFA5, 4'b0000, 32'h0,         3);
    vt[3]  = mk(0, 32'h0000_0103, 0, 3'd4, 32'h0,         32'hA500_0000, 0, 0, 0, 32'h0000_00A5, 4'b0000, 32'h0,         3);
    vt[4]  = mk(0, 32'h0000_0102, 0, 3'd2, 32'h0,         32'h1234_5678, 0, 0, 1, 32'h0,         4'b0000, 32'h0,         1);
    vt[5]  = mk(0, 32'h0000_0102, 0, 3'd1, 32'h0,         32'h8001_0000, 0, 0, 0, 32'hFFFF_8001, 4'b0000, 32'h0,         3);
    vt[6]  = mk(0, 32'h0000_0102, 0, 3'd5, 32'h0,         32'h8001_0000, 0, 0, 0, 32'h0000_8001, 4'b0000, 32'h0,         3);
    vt[7]  = mk(0, 32'h0000_0102, 1, 3'd1, 32'h0000_1234, 32'h0,         0, 0, 0, 32'h0,         4'b1100, 32'h1234_1234, 2);
    vt[8]  = mk(0, 32'h0000_0101, 1, 3'd1, 32'h0000_1234, 32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         1);
    vt[9]  = mk(1, 32'h0000_0207, 0, 3'd0, 32'h0,         32'h0000_0013, 0, 0, 0, 32'h0000_0013, 4'b0000, 32'h0,         3);
    vt[10] = mk(1, 32'h0000_020C, 0, 3'd0, 32'h0,         32'h0010_0093, 5, 0, 0, 32'h0010_0093, 4'b0000, 32'h0,         8);
    vt[11] = mk(0, 32'h0000_0104, 0, 3'd3, 32'h0,         32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D, 4'b0000, 32'h0,         3);
    vt[12] = mk(0, 32'h0000_0105, 0, 3'd7, 32'h0,         32'hCAFE_F00D, 0, 0, 1, 32'h0,         4'b0000, 32'h0,         1);
    vt[13] = mk(0, 32'h0000_010C, 1, 3'd2, 32'h1122_3344, 32'h0,         2, 0, 0, 32'h0,         4'b1111, 32'h1122_3344, 4);
    vt[14] = mk(0, 32'h0000_0108, 0, 3'd2, 32'h0,         32'h89AB_CDEF, 0, 2, 0, 32'h89AB_CDEF, 4'b0000, 32'h0,         5);
    vt[15] = mk(0, 32'h0000_010A, 1, 3'd2, 32'h5555_AAAA, 32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         1);
    vt[16] = mk(0, 32'h0000_0101, 0, 3'd0, 32'h0,         32'h0000_7F00, 0, 0, 0, 32'h0000_007F, 4'b0000, 32'h0,         3);

    for (int i = 0; i < 17; i++) begin
      txn(vt[i], r);
      check_txn($sformatf("vec%0d", i), vt[i], r);
    end

    // Contention: both ports valid every cycle; every fifth grant must go to fetch.
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h0000_0400;
    bus.dc_req_valid = 1'b1; bus.dc_req_addr = 32'h0000_0500;
    bus.dc_req_we = 1'b0; bus.dc_req_size = 3'd2;
    g = 0;
    for (int c = 0; c < 300 && g < 10; c++) begin
      @(negedge clk);
      bus.mem_req_ready  = bus.mem_req_valid;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = $urandom();
      #1;
      if (bus.ic_req_ready || bus.dc_req_ready) begin
        chk("grant_exclusive", {31'd0, bus.ic_req_ready & bus.dc_req_ready}, 32'd0);
        grants_ic[g] = bus.ic_req_ready;
        g++;
      end
    end
    chk("contention_grants", 32'(g), 32'd10);
    @(negedge clk);
    bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
    repeat (6) begin
      bus.mem_req_ready = bus.mem_req_valid; bus.mem_resp_valid = 1'b1;
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("grant%0d_is_ic", i), 32'(grants_ic[i]), 32'(i % 5 == 4));
    end

    // Reset while a fetch waits for its read data; the late response must vanish.
    @(negedge clk);
    bus.ic_req_valid = 1'b1; bus.ic_req_addr = 32'h0000_0300;
    #1;
    chk("rst_seq_ic_ready", {31'd0, bus.ic_req_ready}, 32'd1);
    @(negedge clk);
    bus.ic_req_valid = 1'b0;
    chk("rst_seq_mem_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0BAD_0BAD;
    #1;
    chk("rst_seq_outs_zero", {31'd0, outs_nonzero()}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      chk("rst_seq_no_resp", {31'd0, bus.ic_resp_valid | bus.dc_resp_valid}, 32'd0);
    end
    v = model(1'b1, 32'h0000_0310, 1'b0, 3'd2, 32'd0, 32'h0000_0073, 0, 0);
    txn(v, r);
    check_txn("after_reset", v, r);

    // Random traffic against the behavioural model.
    for (int i = 0; i < 80; i++) begin
      v = model($urandom_range(0, 3) == 0, $urandom(), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), $urandom(), $urandom(),
                $urandom_range(0, 3), $urandom_range(0, 3));
      txn(v, r);
      check_txn($sformatf("rnd%0d", i), v, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
